// File: rtl/fb_write_arbiter_pkg.sv
// Shared widths, framebuffer geometry and types for the framebuffer write arbiter.
package fb_write_arbiter_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned COORD_W = 6;
  localparam int unsigned COLOR_W = 12;
  localparam int unsigned FB_W    = 64;
  localparam int unsigned FB_H    = 64;
  localparam logic [COLOR_W-1:0] CLEAR_COLOR = 12'h000;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
  } pixel_wr_t;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Producer request bundle, clear control and framebuffer write port seen by the arbiter.
interface fb_write_arbiter_if #(
  parameter int unsigned NUM_REQ = fb_write_arbiter_pkg::NUM_REQ,
  parameter int unsigned COORD_W = fb_write_arbiter_pkg::COORD_W,
  parameter int unsigned COLOR_W = fb_write_arbiter_pkg::COLOR_W
) ();

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ-1:0][COORD_W-1:0] req_x;
  logic [NUM_REQ-1:0][COORD_W-1:0] req_y;
  logic [NUM_REQ-1:0][COLOR_W-1:0] req_color;
  logic                            clear_req;
  logic                            clear_busy;
  logic                            write_en;
  logic [COORD_W-1:0]              write_x;
  logic [COORD_W-1:0]              write_y;
  logic [COLOR_W-1:0]              write_color;

  modport slave (
    input  req_valid, req_x, req_y, req_color, clear_req,
    output req_ready, clear_busy, write_en, write_x, write_y, write_color
  );

  modport master (
    output req_valid, req_x, req_y, req_color, clear_req,
    input  req_ready, clear_busy, write_en, write_x, write_y, write_color
  );

endinterface

// File: rtl/fb_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after the pointer, with wrap.
module fb_write_arbiter_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         valid_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest valid requester is the last writer.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(NUM_REQ - 1 - k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (valid_i[cand]) begin
        grant_o       = '0;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
        any_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: round-robin among producers, prioritised full-frame clear sweep.
module fb_write_arbiter #(
  parameter int unsigned          NUM_REQ     = fb_write_arbiter_pkg::NUM_REQ,
  parameter int unsigned          COORD_W     = fb_write_arbiter_pkg::COORD_W,
  parameter int unsigned          COLOR_W     = fb_write_arbiter_pkg::COLOR_W,
  parameter int unsigned          FB_W        = fb_write_arbiter_pkg::FB_W,
  parameter int unsigned          FB_H        = fb_write_arbiter_pkg::FB_H,
  parameter logic [COLOR_W-1:0]   CLEAR_COLOR = fb_write_arbiter_pkg::CLEAR_COLOR
) (
  input  logic               clk,
  input  logic               resetn,
  fb_write_arbiter_if.slave  bus
);

  import fb_write_arbiter_pkg::arb_state_e;
  import fb_write_arbiter_pkg::ARB;
  import fb_write_arbiter_pkg::CLEAR;

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic               wen_q, wen_d;
  logic [COORD_W-1:0] wx_q, wx_d, wy_q, wy_d;
  logic [COLOR_W-1:0] wc_q, wc_d;
  logic               busy_q;
  logic [NUM_REQ-1:0] gnt, ready;
  logic [IDX_W-1:0]   gnt_idx;
  logic               any_gnt;

  fb_write_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid_i (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (gnt),
    .idx_o   (gnt_idx),
    .any_o   (any_gnt)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    wen_d   = 1'b0;
    wx_d    = wx_q;
    wy_d    = wy_q;
    wc_d    = wc_q;
    ready   = '0;
    case (state_q)
      ARB: begin
        if (bus.clear_req) begin
          state_d = CLEAR;
          cx_d    = '0;
          cy_d    = '0;
        end else if (any_gnt) begin
          ready = gnt;
          wen_d = 1'b1;
          wx_d  = bus.req_x[gnt_idx];
          wy_d  = bus.req_y[gnt_idx];
          wc_d  = bus.req_color[gnt_idx];
          ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      CLEAR: begin
        wen_d = 1'b1;
        wx_d  = cx_q;
        wy_d  = cy_q;
        wc_d  = CLEAR_COLOR;
        if (cx_q == COORD_W'(FB_W - 1)) begin
          cx_d = '0;
          if (cy_q == COORD_W'(FB_H - 1)) begin
            cy_d    = '0;
            state_d = ARB;
          end else begin
            cy_d = cy_q + 1'b1;
          end
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Grants are combinational from registered state, so gate them while reset is held.
  assign bus.req_ready = resetn ? ready : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB;
      ptr_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      wen_q   <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
      wc_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      wen_q   <= wen_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      wc_q    <= wc_d;
      busy_q  <= (state_d == CLEAR);
    end
  end

  assign bus.write_en    = wen_q;
  assign bus.write_x     = wx_q;
  assign bus.write_y     = wy_q;
  assign bus.write_color = wc_q;
  assign bus.clear_busy  = busy_q;

endmodule
